delay_sum_beamformer: RTL
=========================

DELAY_SUM_BEAMFORMER -- requirements
Module: delay_sum_beamformer

Interface
REQ-001 Parameter DATA_W, default 32: signed sample width per channel.
REQ-002 Parameter IDX_W, default 16: sample-index width.
REQ-003 Parameter NUM_CH, default 4: channel count (1..16).
REQ-004 Parameter NUM_PTS, default 1024: focal points per frame, which is also the per-channel delay-table depth; PTR_W = clog2(NUM_PTS).
REQ-005 Parameter SUM_W = DATA_W + clog2(NUM_CH): output width.
REQ-006 Port clk, input, 1: sole clock; all logic is rising-edge.
REQ-007 Port reset_n, input, 1: asynchronous active-low reset.
REQ-008 Port startbeamformer, input, 1: pulse starting a frame.
REQ-009 Port in_valid, input, 1: in_data and in_index are valid this cycle.
REQ-010 Port in_data, input, NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-011 Port in_index, input, IDX_W: sample index of in_data.
REQ-012 Ports tbl_we (input, 1), tbl_ch (input, 4), tbl_addr (input, PTR_W) and tbl_data (input, IDX_W): delay-table write port.
REQ-013 Port output_value, output, SUM_W: delay-and-sum result.
REQ-014 Port data_good, output, 1: output_value is valid; single-cycle pulse per point.
REQ-015 Ports busy (output, 1) and done (output, 1): busy is high during a frame; done pulses for one cycle at frame end.

Function
REQ-016 Per-channel delay table: NUM_PTS x IDX_W, synchronous write, 1-cycle registered read; table entries are nondecreasing per channel.
REQ-017 FSM states: IDLE, PRIME, RUN, EMIT, DONE.
REQ-018 IDLE goes to PRIME on startbeamformer; all pointers and capture flags clear.
REQ-019 PRIME lasts exactly one cycle (table read latency), then goes to RUN.
REQ-020 In RUN, per channel c not yet captured: if in_valid and in_index == desired[c], latch in_data channel c and set captured[c]; several channels may capture in the same cycle.
REQ-021 RUN goes to EMIT in the cycle after all captured[] bits are set.
REQ-022 In EMIT:
- output_value is the sign-extended sum of the latched samples, full precision, with no overflow possible;
- data_good = 1 for one cycle;
- pointers increment and captured[] clears.
REQ-023 After EMIT at point index NUM_PTS-1 the FSM goes to DONE; otherwise it goes to PRIME.
REQ-024 DONE pulses done for one cycle, then goes to IDLE.
REQ-025 Latency: data_good asserts 2 cycles after the last capturing in_valid cycle.
REQ-026 startbeamformer is ignored while busy.
REQ-027 tbl_we while busy is ignored; tbl_ch >= NUM_CH is ignored.
REQ-028 in_valid low stalls RUN indefinitely with no timeout.
REQ-029 busy = 1 in every state except IDLE.
REQ-030 output_value holds its last value between data_good pulses.

Reset
REQ-031 reset_n low asynchronously forces state to IDLE and sets output_value, data_good, busy, done, pointers, captured[] and latched samples to 0.
REQ-032 Reset mid-frame aborts the frame with no done pulse.
REQ-033 Table contents are not reset.

Configuration
REQ-034 Macro BF_OVERRUN_CHECK_EN selects overrun checking.
REQ-035 With BF_OVERRUN_CHECK_EN defined:
- output port overrun (1) is added;
- overrun is sticky, set when in RUN an uncaptured channel sees in_valid with in_index > desired[c];
- overrun is cleared by reset or startbeamformer accepted in IDLE;
- the frame continues unaffected.
REQ-036 Without BF_OVERRUN_CHECK_EN: the port and logic are absent, and behaviour is otherwise identical.

Verification
REQ-037 Scenario "basic": NUM_CH=4, NUM_PTS=2, tables ch0..3 = {3,7},{4,8},{5,9},{6,10}, in_index 0..12 with in_data[ch]=index*10+ch -> data_good at points 0 and 1 with output_value 186 and 346, then one done pulse.
REQ-038 Scenario "same-cycle capture": all tables = {2}, in_data = {-5,1,1,1} at index 2 -> output_value = -2, data_good 2 cycles after the index-2 beat.
REQ-039 Scenario "stall": in_valid deasserted 20 cycles between index 4 and 5 -> identical results to the basic scenario, busy held high.
REQ-040 Scenario "reset mid-frame": reset_n low after the first data_good -> all outputs 0 and state IDLE; a new start rescans from point 0.
REQ-041 Scenario "ignored writes and starts": tbl_we and startbeamformer asserted while busy -> table and frame unchanged.
REQ-042 Scenario "overrun" (macro defined): ch0 table {3}, stream skips index 3 (2 then 4) -> overrun = 1 from the index-4 beat until the next accepted start.

Source files
------------

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer.
//
// For every focal point of a frame, each channel waits for the input beat
// whose sample index equals that channel's entry in its delay table. It
// latches that sample. Once every channel has latched its sample, the
// sign-extended full-precision sum is emitted with a one-cycle data_good
// pulse. The frame then moves on to the next focal point.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   startbeamformer     start a frame (ignored while busy)
//   in_valid/in_data/in_index   sample stream, channel c at [c*DATA_W +: DATA_W]
//   tbl_we/tbl_ch/tbl_addr/tbl_data   delay-table write port (IDLE only)
//   output_value        delay-and-sum result, held between pulses
//   data_good           one-cycle pulse per focal point
//   busy, done          frame active / one-cycle end-of-frame pulse
//   overrun             (only with BF_OVERRUN_CHECK_EN) sticky flag: a
//                       channel's wanted index was skipped by the stream
//
// Build option: define BF_OVERRUN_CHECK_EN to add the overrun port and logic.
module delay_sum_beamformer #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16,
  parameter int NUM_CH  = 4,
  parameter int NUM_PTS = 1024,
  localparam int PTR_W  = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1,
  parameter int SUM_W   = DATA_W + $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     startbeamformer,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]         in_index,
  input  logic                     tbl_we,
  input  logic [3:0]               tbl_ch,
  input  logic [PTR_W-1:0]         tbl_addr,
  input  logic [IDX_W-1:0]         tbl_data,
  output logic [SUM_W-1:0]         output_value,
  output logic                     data_good,
  output logic                     busy,
  output logic                     done
`ifdef BF_OVERRUN_CHECK_EN
  ,output logic                    overrun
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_EMIT, S_DONE} state_t;

  localparam logic [PTR_W-1:0] LAST_PT = PTR_W'(NUM_PTS - 1);

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q;
  logic [NUM_CH-1:0]        cap_q;
  logic [NUM_CH-1:0]        hit;
  logic signed [DATA_W-1:0] samp_q [NUM_CH];
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  out_q;
  logic                     dg_q;
  logic [IDX_W-1:0]         desired [NUM_CH];

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return SUM_W'(x);
  endfunction

  // Delay tables: write only while idle, registered read of the current point.
  // The read runs every cycle, so the entry for ptr_q is ready one cycle
  // after ptr_q changes. PRIME covers that cycle.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [IDX_W-1:0] mem_q [NUM_PTS];
    logic [IDX_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (tbl_we && (state_q == S_IDLE) && (tbl_ch == 4'(c)) && (int'(tbl_addr) < NUM_PTS))
        mem_q[tbl_addr] <= tbl_data;
      rd_q <= mem_q[ptr_q];
    end

    assign desired[c] = rd_q;
  end

  // Capture match per channel; already captured channels are left alone.
  always_comb begin
    hit = '0;
    for (int c = 0; c < NUM_CH; c++)
      if ((state_q == S_RUN) && in_valid && !cap_q[c] && (in_index == desired[c]))
        hit[c] = 1'b1;
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NUM_CH; c++)
      sum_d = sum_d + sext(samp_q[c]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (startbeamformer) state_d = S_PRIME;
      S_PRIME: state_d = S_RUN;
      S_RUN:   if (&cap_q) state_d = S_EMIT;
      S_EMIT:  state_d = (ptr_q == LAST_PT) ? S_DONE : S_PRIME;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The sum is registered on the RUN->EMIT edge. data_good and output_value
  // are therefore valid during EMIT, two cycles after the last capture beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cap_q   <= '0;
      out_q   <= '0;
      dg_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) samp_q[c] <= '0;
    end else begin
      state_q <= state_d;
      dg_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (startbeamformer) begin
            ptr_q <= '0;
            cap_q <= '0;
          end
        end
        S_RUN: begin
          for (int c = 0; c < NUM_CH; c++)
            if (hit[c]) samp_q[c] <= in_data[c*DATA_W +: DATA_W];
          cap_q <= cap_q | hit;
          if (&cap_q) begin
            out_q <= sum_d;
            dg_q  <= 1'b1;
          end
        end
        S_EMIT: begin
          ptr_q <= ptr_q + PTR_W'(1);
          cap_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign output_value = out_q;
  assign data_good    = dg_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

`ifdef BF_OVERRUN_CHECK_EN
  logic ovr_hit;
  logic ovr_q;

  // A still-waiting channel seeing a later index means its sample was skipped.
  always_comb begin
    ovr_hit = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if ((state_q == S_RUN) && in_valid && !cap_q[c] && (in_index > desired[c]))
        ovr_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovr_q <= 1'b0;
    else if ((state_q == S_IDLE) && startbeamformer)
      ovr_q <= 1'b0;
    else if (ovr_hit)
      ovr_q <= 1'b1;
  end

  assign overrun = ovr_q;
`endif

endmodule
